// File: rtl/izh_seq_pkg.sv
// Shared definitions for the Izhikevich timestep sequencer: state encoding,
// default update-pipeline latency and the datapath word-width rule.
package izh_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_DRAIN     = 3'd2;
  localparam logic [2:0] ST_PROPAGATE = 3'd3;
  localparam logic [2:0] ST_SWAP      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ISSUE     = ST_ISSUE,
    S_DRAIN     = ST_DRAIN,
    S_PROPAGATE = ST_PROPAGATE,
    S_SWAP      = ST_SWAP
  } seq_state_e;

  // Update-pipeline latency from issue to v_prime/fired valid.
  localparam int DEF_PIPE_LAT = 4;

  // Datapath words are sign-magnitude: one sign bit on top of the magnitude.
  function automatic int word_width(input int numwidth);
    return numwidth + 1;
  endfunction

endpackage

// File: rtl/izh_tag_delay_line.sv
// Valid+tag shift register matching the update-pipeline latency, so that a tag
// issued in cycle t reappears as a writeback in cycle t+DEPTH.
module izh_tag_delay_line
  import izh_seq_pkg::*;
#(
  parameter int TAGBITS = 4,
  parameter int DEPTH   = DEF_PIPE_LAT
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [TAGBITS-1:0] in_tag,
  output logic               out_valid,
  output logic [TAGBITS-1:0] out_tag
);

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][TAGBITS-1:0] tag_q, tag_d;

  // Shift every stage one position towards the output.
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    valid_d[0] = in_valid;
    tag_d[0]   = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
  end

  // Clear drops everything in flight so no stale writeback can follow it.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/izh_timestep_sequencer.sv
// Autonomous timestep controller: sweeps all neuron tags through the update
// pipeline, aligns writebacks/enqueues, waits for spike propagation and
// pulses swap, for a programmed number of timesteps.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start; abort ignored
// ISSUE     | one tag per cycle, 0 .. NUMNEURONS-1
// DRAIN     | PIPE_LAT cycles while in-flight writebacks retire
// PROPAGATE | waiting for spike FIFO empty and CIM idle
// SWAP      | one-cycle swap pulse, step count and spike summary update
module izh_timestep_sequencer
  import izh_seq_pkg::*;
#(
  parameter int NUMWIDTH = 16,
  parameter int TAGBITS  = 4,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int STEPBITS = 16
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_start,
  input  logic                in_abort,
  input  logic [STEPBITS-1:0] in_num_steps,
  input  logic                in_fired,
  input  logic                in_fifo_full,
  input  logic                in_fifo_empty,
  input  logic                in_cim_busy,
  output logic [TAGBITS-1:0]  out_tag,
  output logic                out_issue_valid,
  output logic                out_wb_en,
  output logic [TAGBITS-1:0]  out_wb_tag,
  output logic                out_enq,
  output logic [TAGBITS-1:0]  out_enq_tag,
  output logic                out_swap,
  output logic                out_busy,
  output logic                out_done,
  output logic [STEPBITS-1:0] out_step_count,
  output logic [TAGBITS:0]    out_last_spikes,
  output logic                out_overflow
);

  localparam int NUMNEURONS = 2 ** TAGBITS;
  localparam int WORD_W     = word_width(NUMWIDTH);
  localparam int DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [TAGBITS-1:0] LAST_TAG   = TAGBITS'(NUMNEURONS - 1);
  localparam logic [TAGBITS:0]   SPIKE_MAX  = (TAGBITS + 1)'(NUMNEURONS);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);

  // The neighbouring datapath needs a sign bit plus at least one magnitude
  // bit, and the drain timer needs at least one cycle of pipeline latency.
  if (PIPE_LAT < 1 || WORD_W < 2) begin : g_param_check
    $error("izh_timestep_sequencer: PIPE_LAT must be >= 1 and NUMWIDTH >= 1");
  end

  seq_state_e          state_q, state_d;
  logic [TAGBITS-1:0]  tag_q, tag_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [STEPBITS-1:0] steps_q, steps_d;
  logic [STEPBITS-1:0] step_count_q, step_count_d;
  logic [TAGBITS:0]    spike_cnt_q, spike_cnt_d;
  logic [TAGBITS:0]    last_spikes_q, last_spikes_d;
  logic                overflow_q, overflow_d;
  logic                abort_pend_q, abort_pend_d;
  logic                done_q, done_d;

  logic                issue_valid;
  logic                wb_en;
  logic [TAGBITS-1:0]  wb_tag;
  logic                enq;

  assign issue_valid = (state_q == S_ISSUE);
  assign enq         = wb_en & in_fired;

  izh_tag_delay_line #(
    .TAGBITS (TAGBITS),
    .DEPTH   (PIPE_LAT)
  ) u_delay (
    .clk       (in_clk),
    .clr       (in_reset),
    .in_valid  (issue_valid),
    .in_tag    (tag_q),
    .out_valid (wb_en),
    .out_tag   (wb_tag)
  );

  // Next-state, counters and spike accounting for the sequencer.
  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    drain_cnt_d   = drain_cnt_q;
    steps_d       = steps_q;
    step_count_d  = step_count_q;
    spike_cnt_d   = spike_cnt_q;
    last_spikes_d = last_spikes_q;
    overflow_d    = overflow_q;
    abort_pend_d  = abort_pend_q;
    done_d        = 1'b0;

    // Enqueues only happen while writebacks retire (ISSUE/DRAIN); a spike
    // lost to a full FIFO is flagged but never retried.
    if (enq && (spike_cnt_q != SPIKE_MAX)) begin
      spike_cnt_d = spike_cnt_q + 1'b1;
    end
    if (enq && in_fifo_full) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          if (in_num_steps != '0) begin
            state_d      = S_ISSUE;
            steps_d      = in_num_steps;
            step_count_d = '0;
            spike_cnt_d  = '0;
            overflow_d   = 1'b0;
            abort_pend_d = 1'b0;
            tag_d        = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (in_abort || (tag_q == LAST_TAG)) begin
          state_d      = S_DRAIN;
          drain_cnt_d  = DRAIN_LOAD;
          tag_d        = '0;
          abort_pend_d = abort_pend_q | in_abort;
        end else begin
          tag_d = tag_q + 1'b1;
        end
      end

      S_DRAIN: begin
        abort_pend_d = abort_pend_q | in_abort;
        if (drain_cnt_q == '0) begin
          if (abort_pend_q || in_abort) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PROPAGATE;
          end
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end

      S_PROPAGATE: begin
        if (in_abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (in_fifo_empty && !in_cim_busy) begin
          state_d       = S_SWAP;
          step_count_d  = step_count_q + STEPBITS'(1);
          last_spikes_d = spike_cnt_q;
          spike_cnt_d   = '0;
          done_d        = (step_count_d == steps_q);
        end
      end

      S_SWAP: begin
        tag_d = '0;
        if (step_count_q == steps_q) begin
          state_d = S_IDLE;
        end else if (in_abort) begin
          // The final-step done has not been given yet, so give it on IDLE entry.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single register bank for the sequencer state and its outputs.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q       <= S_IDLE;
      tag_q         <= '0;
      drain_cnt_q   <= '0;
      steps_q       <= '0;
      step_count_q  <= '0;
      spike_cnt_q   <= '0;
      last_spikes_q <= '0;
      overflow_q    <= 1'b0;
      abort_pend_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      drain_cnt_q   <= drain_cnt_d;
      steps_q       <= steps_d;
      step_count_q  <= step_count_d;
      spike_cnt_q   <= spike_cnt_d;
      last_spikes_q <= last_spikes_d;
      overflow_q    <= overflow_d;
      abort_pend_q  <= abort_pend_d;
      done_q        <= done_d;
    end
  end

  assign out_tag         = tag_q;
  assign out_issue_valid = issue_valid;
  assign out_wb_en       = wb_en;
  assign out_wb_tag      = wb_tag;
  assign out_enq         = enq;
  assign out_enq_tag     = wb_tag;
  assign out_swap        = (state_q == S_SWAP);
  assign out_busy        = (state_q != S_IDLE);
  assign out_done        = done_q;
  assign out_step_count  = step_count_q;
  assign out_last_spikes = last_spikes_q;
  assign out_overflow    = overflow_q;

endmodule

// File: tb/tb_izh_timestep_sequencer.sv
// Scoreboard bench for izh_timestep_sequencer with TAGBITS=2, PIPE_LAT=4.
// Scenario stimulus pushes hand-computed expected events (absolute cycle and
// value); a negedge monitor pops and compares whenever the DUT presents one.
module tb_izh_timestep_sequencer;

  localparam int NUMWIDTH = 16;
  localparam int TAGBITS  = 2;
  localparam int PIPE_LAT = 4;
  localparam int STEPBITS = 16;

  logic                clk = 1'b0;
  logic                in_reset, in_start, in_abort, in_fired;
  logic                in_fifo_full, in_fifo_empty, in_cim_busy;
  logic [STEPBITS-1:0] in_num_steps;
  logic [TAGBITS-1:0]  out_tag, out_wb_tag, out_enq_tag;
  logic                out_issue_valid, out_wb_en, out_enq, out_swap;
  logic                out_busy, out_done, out_overflow;
  logic [STEPBITS-1:0] out_step_count;
  logic [TAGBITS:0]    out_last_spikes;

  always #5 clk = ~clk;

  izh_timestep_sequencer #(
    .NUMWIDTH (NUMWIDTH),
    .TAGBITS  (TAGBITS),
    .PIPE_LAT (PIPE_LAT),
    .STEPBITS (STEPBITS)
  ) dut (
    .in_clk          (clk),
    .in_reset        (in_reset),
    .in_start        (in_start),
    .in_abort        (in_abort),
    .in_num_steps    (in_num_steps),
    .in_fired        (in_fired),
    .in_fifo_full    (in_fifo_full),
    .in_fifo_empty   (in_fifo_empty),
    .in_cim_busy     (in_cim_busy),
    .out_tag         (out_tag),
    .out_issue_valid (out_issue_valid),
    .out_wb_en       (out_wb_en),
    .out_wb_tag      (out_wb_tag),
    .out_enq         (out_enq),
    .out_enq_tag     (out_enq_tag),
    .out_swap        (out_swap),
    .out_busy        (out_busy),
    .out_done        (out_done),
    .out_step_count  (out_step_count),
    .out_last_spikes (out_last_spikes),
    .out_overflow    (out_overflow)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
  } exp_t;

  exp_t q_issue[$];
  exp_t q_wb[$];
  exp_t q_swap[$];
  exp_t q_done[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Scenario description, all cycles relative to t0 (the start cycle); -1 = unused.
  int t0 = 0;
  int s_steps, s_steps2, s_start2, s_abort, s_fire_a, s_fire_b, s_full;
  int s_busy_lo, s_busy_hi, s_nempty_lo, s_nempty_hi, s_reset;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void unexpected(input string name, input int val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected output value %0d at cycle %0d, none required", name, val, cyc);
  endfunction

  function automatic void push_issue(input int r, input int tag);
    exp_t e;
    e.cyc = t0 + r; e.a = tag; e.b = 0;
    q_issue.push_back(e);
  endfunction

  function automatic void push_wb(input int r, input int tag, input int enq);
    exp_t e;
    e.cyc = t0 + r; e.a = tag; e.b = enq;
    q_wb.push_back(e);
  endfunction

  function automatic void push_swap(input int r, input int steps, input int spikes);
    exp_t e;
    e.cyc = t0 + r; e.a = steps; e.b = spikes;
    q_swap.push_back(e);
  endfunction

  function automatic void push_done(input int r, input int steps);
    exp_t e;
    e.cyc = t0 + r; e.a = steps; e.b = 0;
    q_done.push_back(e);
  endfunction

  // Full sweep: tags 0..3 from cycle r, writebacks PIPE_LAT later.
  function automatic void push_sweep(input int r, input logic [3:0] enq_mask);
    for (int k = 0; k < 4; k++) begin
      push_issue(r + k, k);
      push_wb(r + 4 + k, k, int'(enq_mask[k]));
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_issue_valid) begin
      if (q_issue.size() == 0) unexpected("issue", int'(out_tag));
      else begin
        e = q_issue.pop_front();
        check("issue_cycle", cyc, e.cyc);
        check("issue_tag", int'(out_tag), e.a);
      end
    end
    if (out_wb_en) begin
      if (q_wb.size() == 0) unexpected("writeback", int'(out_wb_tag));
      else begin
        e = q_wb.pop_front();
        check("wb_cycle", cyc, e.cyc);
        check("wb_tag", int'(out_wb_tag), e.a);
        check("wb_enq", int'(out_enq), e.b);
        if (e.b != 0) check("enq_tag", int'(out_enq_tag), e.a);
      end
    end else if (out_enq) begin
      unexpected("enq_without_wb", int'(out_enq_tag));
    end
    if (out_swap) begin
      if (q_swap.size() == 0) unexpected("swap", int'(out_step_count));
      else begin
        e = q_swap.pop_front();
        check("swap_cycle", cyc, e.cyc);
        check("swap_step_count", int'(out_step_count), e.a);
        check("swap_last_spikes", int'(out_last_spikes), e.b);
      end
    end
    if (out_done) begin
      if (q_done.size() == 0) unexpected("done", int'(out_step_count));
      else begin
        e = q_done.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_step_count", int'(out_step_count), e.a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_scn();
    s_steps = 0; s_steps2 = 0; s_start2 = -1; s_abort = -1;
    s_fire_a = -1; s_fire_b = -1; s_full = -1;
    s_busy_lo = -1; s_busy_hi = -1; s_nempty_lo = -1; s_nempty_hi = -1;
    s_reset = -1;
  endtask

  task automatic drive_inputs();
    int r;
    r = cyc - t0;
    in_reset      = (r == s_reset);
    in_start      = (r == 0) || (r == s_start2);
    in_num_steps  = (r == s_start2) ? STEPBITS'(s_steps2) : STEPBITS'(s_steps);
    in_abort      = (r == s_abort);
    in_fired      = (r == s_fire_a) || (r == s_fire_b);
    in_fifo_full  = (r == s_full);
    in_cim_busy   = (r >= s_busy_lo) && (r <= s_busy_hi);
    in_fifo_empty = !((r >= s_nempty_lo) && (r <= s_nempty_hi));
  endtask

  task automatic start_scn();
    t0 = cyc;
    drive_inputs();
  endtask

  task automatic run_to(input int r_end);
    while ((cyc - t0) < r_end) begin
      tick();
      drive_inputs();
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_left_issue"}, q_issue.size(), 0);
    check({name, "_left_wb"},    q_wb.size(),    0);
    check({name, "_left_swap"},  q_swap.size(),  0);
    check({name, "_left_done"},  q_done.size(),  0);
  endtask

  initial begin
    in_reset = 1'b1; in_start = 1'b0; in_abort = 1'b0; in_fired = 1'b0;
    in_fifo_full = 1'b0; in_fifo_empty = 1'b1; in_cim_busy = 1'b0;
    in_num_steps = '0;
    clear_scn();
    repeat (3) tick();

    check("rst_busy",        int'(out_busy), 0);
    check("rst_issue_valid", int'(out_issue_valid), 0);
    check("rst_tag",         int'(out_tag), 0);
    check("rst_wb_en",       int'(out_wb_en), 0);
    check("rst_swap",        int'(out_swap), 0);
    check("rst_done",        int'(out_done), 0);
    check("rst_step_count",  int'(out_step_count), 0);
    check("rst_last_spikes", int'(out_last_spikes), 0);
    check("rst_overflow",    int'(out_overflow), 0);
    in_reset = 1'b0;
    tick();

    // A: single step, no spikes.
    clear_scn(); s_steps = 1;
    start_scn();
    push_sweep(1, 4'b0000); push_swap(10, 1, 0); push_done(10, 1);
    run_to(11);
    check("A_busy_c11", int'(out_busy), 0);
    check("A_step_count", int'(out_step_count), 1);
    run_to(13);
    check_drained("A");

    // B: spikes on tags 1 and 3; FIFO full on the second enqueue.
    clear_scn(); s_steps = 1; s_fire_a = 6; s_fire_b = 8; s_full = 8;
    start_scn();
    push_sweep(1, 4'b1010); push_swap(10, 1, 2); push_done(10, 1);
    run_to(7);
    check("B_overflow_c7", int'(out_overflow), 0);
    run_to(9);
    check("B_overflow_c9", int'(out_overflow), 1);
    run_to(12);
    check("B_overflow_sticky", int'(out_overflow), 1);
    check("B_last_spikes", int'(out_last_spikes), 2);
    check_drained("B");

    // F: overflow clears on accepted start; reset mid-run discards writebacks.
    clear_scn(); s_steps = 1; s_reset = 3;
    start_scn();
    check("F_overflow_c0", int'(out_overflow), 1);
    push_issue(1, 0); push_issue(2, 1); push_issue(3, 2);
    run_to(1);
    check("F_overflow_c1", int'(out_overflow), 0);
    run_to(4);
    check("F_rst_busy",        int'(out_busy), 0);
    check("F_rst_issue_valid", int'(out_issue_valid), 0);
    check("F_rst_tag",         int'(out_tag), 0);
    check("F_rst_wb_en",       int'(out_wb_en), 0);
    check("F_rst_last_spikes", int'(out_last_spikes), 0);
    check("F_rst_step_count",  int'(out_step_count), 0);
    run_to(12);
    check_drained("F");

    // C: three steps, CIM busy 9..15, ignored start at 12.
    clear_scn(); s_steps = 3; s_busy_lo = 9; s_busy_hi = 15; s_start2 = 12; s_steps2 = 5;
    start_scn();
    push_sweep(1, 4'b0000);  push_swap(17, 1, 0);
    push_sweep(18, 4'b0000); push_swap(27, 2, 0);
    push_sweep(28, 4'b0000); push_swap(37, 3, 0); push_done(37, 3);
    run_to(16);
    check("C_busy_propagate", int'(out_busy), 1);
    run_to(38);
    check("C_busy_end", int'(out_busy), 0);
    check("C_step_count", int'(out_step_count), 3);
    run_to(41);
    check_drained("C");

    // D: abort during ISSUE.
    clear_scn(); s_steps = 2; s_abort = 2;
    start_scn();
    push_issue(1, 0); push_issue(2, 1);
    push_wb(5, 0, 0); push_wb(6, 1, 0);
    push_done(7, 0);
    run_to(6);
    check("D_busy_drain", int'(out_busy), 1);
    run_to(7);
    check("D_busy_idle", int'(out_busy), 0);
    run_to(9);
    check("D_step_count", int'(out_step_count), 0);
    check_drained("D");

    // E: zero steps; abort while idle is ignored.
    clear_scn(); s_steps = 0; s_abort = 3;
    start_scn();
    push_done(1, 0);
    run_to(1);
    check("E_busy", int'(out_busy), 0);
    run_to(7);
    check_drained("E");

    // G: abort while waiting on a non-empty FIFO in PROPAGATE.
    clear_scn(); s_steps = 2; s_nempty_lo = 9; s_nempty_hi = 20; s_abort = 12;
    start_scn();
    push_sweep(1, 4'b0000); push_done(13, 0);
    run_to(12);
    check("G_busy_propagate", int'(out_busy), 1);
    run_to(13);
    check("G_busy_idle", int'(out_busy), 0);
    run_to(22);
    check("G_step_count", int'(out_step_count), 0);
    check_drained("G");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
